// File: rtl/uart_pkg.sv
`timescale 1ns / 1ps
// uart_pkg
// Definitions shared by the UART receive and transmit paths.
//   uart_state_e         : receiver state encoding (3 bits)
//   DATA_BITS            : data bits per frame (8N1 framing)
//   DEFAULT_CLKS_PER_BIT : system clocks per bit period at the board baud rate
package uart_pkg;

  localparam int DATA_BITS            = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 2080;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } uart_state_e;

endpackage : uart_pkg

// File: rtl/sync_2ff.sv
`timescale 1ns / 1ps
// sync_2ff
// Two-flop synchronizer for asynchronous inputs. Both flops load RESET_VAL
// on reset, so the synchronized output shows the input's inactive level
// until real samples have propagated through.
//   clk_i   : destination clock
//   rst_ni  : asynchronous active-low reset
//   d_i     : asynchronous input
//   q_o     : synchronized output, two clk_i cycles behind d_i
module sync_2ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // NOTE: clocked state uses non-blocking assignments, so sync_q takes the old
  // meta_q and the chain really is two flops deep.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule : sync_2ff

// File: rtl/uart_rx.sv
`timescale 1ns / 1ps
// uart_rx
// 8N1 asynchronous serial receiver, LSB first, idle-high line. The raw line
// is synchronized and then sampled at the middle of each bit by a bit-period
// counter running on the system clock.
//   clock       : system clock
//   reset_n     : asynchronous active-low reset
//   rxd         : raw serial line, asynchronous to clock
//   data        : last correctly framed byte; holds until the next good byte
//   data_valid  : one-cycle strobe, data is new this cycle
//   frame_error : one-cycle strobe, stop bit sampled low
//   busy        : high whenever the receiver is not idle
// CLKS_PER_BIT must be even and >= 8; CNT_W must satisfy 2**CNT_W > CLKS_PER_BIT.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int CNT_W        = 12
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  output logic                 frame_error,
  output logic                 busy
);

  localparam int               IDX_W    = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  logic rxd_s;

  // Line idles high, so the synchronizer resets to 1 to avoid a fake start bit.
  sync_2ff #(
    .WIDTH    (1),
    .RESET_VAL(1'b1)
  ) u_sync_rxd (
    .clk_i (clock),
    .rst_ni(reset_n),
    .d_i   (rxd),
    .q_o   (rxd_s)
  );

  uart_state_e          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q,   cnt_d;
  logic [IDX_W-1:0]     idx_q,   idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q,  data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q,  ferr_d;
  logic                 busy_q,  busy_d;

  always_comb begin
    // NOTE: every _d gets a default before the case, so no path leaves one
    // unassigned and no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!rxd_s) begin
          state_d = ST_START;
          cnt_d   = '0;
        end
      end

      // Re-check the line half a bit in: a high level means the falling edge
      // was a glitch, not a start bit.
      ST_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rxd_s ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // Counting from mid start bit, each full period lands on a bit centre.
      // Shifting in from the top leaves the first (LSB) bit at bit 0.
      ST_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
          if (idx_q == LAST_IDX) begin
            state_d = ST_STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // Leaving at mid stop bit gives half a bit of margin to catch a start
      // bit that follows with no idle time.
      ST_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (rxd_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = ST_BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // A held-low line reports one frame error, then waits here for idle.
      ST_BREAK: begin
        if (rxd_s) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
    end
  end

  assign data        = data_q;
  assign data_valid  = valid_q;
  assign frame_error = ferr_q;
  assign busy        = busy_q;

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
`timescale 1ns / 1ps
// tb_uart_rx
// Self-checking bench for uart_rx at CLKS_PER_BIT = 16 (clock period 10 ns,
// nominal bit time 160 ns). A table of whole frames is replayed first-to-last,
// followed by hand-written sequences for the multi-cycle corner cases.
module tb_uart_rx;

  localparam int  CPB      = 16;
  localparam real CLK_NS   = 10.0;
  localparam real BIT_NS   = 160.0;
  localparam int  LAT_NOM  = 2 + CPB / 2 + 9 * CPB;  // 154

  logic       clock;
  logic       reset_n;
  logic       rxd;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_error;
  logic       busy;

  uart_rx #(
    .CLKS_PER_BIT(CPB),
    .CNT_W       (5)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .rxd        (rxd),
    .data       (data),
    .data_valid (data_valid),
    .frame_error(frame_error),
    .busy       (busy)
  );

  initial begin
    clock = 1'b0;
    forever #(CLK_NS / 2.0) clock = ~clock;
  end

  // Cycle count and strobe monitor. Strobes are sampled on the falling edge.
  int         cyc = 0;
  int         valid_cyc_q[$];
  logic [7:0] valid_data_q[$];
  int         ferr_cyc_q[$];
  int         both_cyc_q[$];

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (data_valid) begin
      valid_cyc_q.push_back(cyc);
      valid_data_q.push_back(data);
    end
    if (frame_error) ferr_cyc_q.push_back(cyc);
    if (data_valid && frame_error) both_cyc_q.push_back(cyc);
  end

  int n_checks = 0;
  int n_fail   = 0;
  int start_cyc;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic check_range(input string name, input int actual, input int lo, input int hi);
    n_checks++;
    if (actual < lo || actual > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
    end
  endtask

  task automatic clear_mon();
    valid_cyc_q.delete();
    valid_data_q.delete();
    ferr_cyc_q.delete();
  endtask

  // Half a nanosecond after a falling edge keeps line changes clear of the
  // rising edge, including the drifting 16.3/15.7-cycle bit times.
  task automatic align();
    @(negedge clock);
    #0.5;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Drives start, 8 data bits LSB first, then the stop level for one bit time.
  // The line is left at the stop level, so frames chain with no idle gap.
  task automatic send_frame(input logic [7:0] b, input logic stop_val, input real bit_ns);
    rxd       = 1'b0;
    start_cyc = cyc;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      #(bit_ns);
    end
    rxd = stop_val;
    #(bit_ns);
  endtask

  // Latency in clock edges from the first rising edge after the start edge.
  function automatic int latency(input int strobe_cyc);
    return strobe_cyc - (start_cyc + 1);
  endfunction

  typedef struct {
    logic [7:0] tx;
    logic       stop;
    real        bit_ns;
    logic [7:0] exp_data;
    int         exp_valid;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{tx: 8'h55, stop: 1'b1, bit_ns: 160.0, exp_data: 8'h55, exp_valid: 1, exp_ferr: 0};
    vecs[1] = '{tx: 8'h00, stop: 1'b1, bit_ns: 160.0, exp_data: 8'h00, exp_valid: 1, exp_ferr: 0};
    vecs[2] = '{tx: 8'hFF, stop: 1'b1, bit_ns: 160.0, exp_data: 8'hFF, exp_valid: 1, exp_ferr: 0};
    vecs[3] = '{tx: 8'hE7, stop: 1'b0, bit_ns: 160.0, exp_data: 8'hFF, exp_valid: 0, exp_ferr: 1};
    vecs[4] = '{tx: 8'hC6, stop: 1'b1, bit_ns: 163.0, exp_data: 8'hC6, exp_valid: 1, exp_ferr: 0};
    vecs[5] = '{tx: 8'h3C, stop: 1'b1, bit_ns: 157.0, exp_data: 8'h3C, exp_valid: 1, exp_ferr: 0};
    vecs[6] = '{tx: 8'h96, stop: 1'b1, bit_ns: 160.0, exp_data: 8'h96, exp_valid: 1, exp_ferr: 0};

    // ---------------- reset values ----------------
    rxd     = 1'b1;
    reset_n = 1'b0;
    #1;
    check("reset data", int'(data), 8'h00);
    check("reset data_valid", int'(data_valid), 0);
    check("reset frame_error", int'(frame_error), 0);
    check("reset busy", int'(busy), 0);
    wait_cycles(3);
    #0.5;
    reset_n = 1'b1;
    wait_cycles(5);
    check("idle busy after reset", int'(busy), 0);
    check("idle data after reset", int'(data), 8'h00);

    // ---------------- table of single frames ----------------
    foreach (vecs[i]) begin
      align();
      clear_mon();
      send_frame(vecs[i].tx, vecs[i].stop, vecs[i].bit_ns);
      rxd = 1'b1;
      wait_cycles(2 * CPB);
      check($sformatf("vec%0d data", i), int'(data), int'(vecs[i].exp_data));
      check($sformatf("vec%0d valid pulses", i), valid_cyc_q.size(), vecs[i].exp_valid);
      check($sformatf("vec%0d ferr pulses", i), ferr_cyc_q.size(), vecs[i].exp_ferr);
      check($sformatf("vec%0d busy idle", i), int'(busy), 0);
      if (vecs[i].exp_valid == 1 && vecs[i].bit_ns == BIT_NS && valid_cyc_q.size() == 1)
        check_range($sformatf("vec%0d latency", i), latency(valid_cyc_q[0]),
                    LAT_NOM - 1, LAT_NOM + 1);
    end

    // ---------------- back-to-back frames, zero idle gap ----------------
    align();
    clear_mon();
    send_frame(8'hA3, 1'b1, BIT_NS);
    send_frame(8'h0F, 1'b1, BIT_NS);
    rxd = 1'b1;
    wait_cycles(2 * CPB);
    check("b2b valid pulses", valid_cyc_q.size(), 2);
    check("b2b ferr pulses", ferr_cyc_q.size(), 0);
    if (valid_cyc_q.size() == 2) begin
      check("b2b first byte", int'(valid_data_q[0]), 8'hA3);
      check("b2b second byte", int'(valid_data_q[1]), 8'h0F);
      check_range("b2b spacing", valid_cyc_q[1] - valid_cyc_q[0], 10 * CPB - 1, 10 * CPB + 1);
    end
    check("b2b final data", int'(data), 8'h0F);

    // ---------------- 3-cycle glitch on idle line ----------------
    align();
    clear_mon();
    rxd = 1'b0;
    #(3 * CLK_NS);
    rxd = 1'b1;
    check("glitch enters start", int'(busy), 1);
    wait_cycles(CPB + 4);
    check("glitch busy returns 0", int'(busy), 0);
    check("glitch valid pulses", valid_cyc_q.size(), 0);
    check("glitch ferr pulses", ferr_cyc_q.size(), 0);
    check("glitch data held", int'(data), 8'h0F);

    // ---------------- framing error then break ----------------
    align();
    clear_mon();
    send_frame(8'h3C, 1'b0, BIT_NS);
    wait_cycles(100);
    check("break busy while low", int'(busy), 1);
    check("break one ferr pulse", ferr_cyc_q.size(), 1);
    check("break no valid", valid_cyc_q.size(), 0);
    check("break data held", int'(data), 8'h0F);
    rxd = 1'b1;
    wait_cycles(5);
    check("break busy released", int'(busy), 0);
    align();
    clear_mon();
    send_frame(8'h81, 1'b1, BIT_NS);
    rxd = 1'b1;
    wait_cycles(2 * CPB);
    check("after break data", int'(data), 8'h81);
    check("after break valid pulses", valid_cyc_q.size(), 1);
    check("after break ferr pulses", ferr_cyc_q.size(), 0);

    // ---------------- reset during bit 4 of 0xFF ----------------
    align();
    clear_mon();
    rxd = 1'b0;
    #(BIT_NS);
    rxd = 1'b1;                      // bits 0..7 and stop of 0xFF are all high
    #(4 * BIT_NS + BIT_NS / 2.0);    // middle of bit 4
    check("pre-reset busy", int'(busy), 1);
    reset_n = 1'b0;
    #1;
    check("mid reset data", int'(data), 8'h00);
    check("mid reset busy", int'(busy), 0);
    check("mid reset data_valid", int'(data_valid), 0);
    check("mid reset frame_error", int'(frame_error), 0);
    wait_cycles(3);
    #0.5;
    reset_n = 1'b1;
    wait_cycles(12 * CPB);
    check("post reset valid pulses", valid_cyc_q.size(), 0);
    check("post reset ferr pulses", ferr_cyc_q.size(), 0);
    check("post reset busy", int'(busy), 0);
    align();
    clear_mon();
    send_frame(8'h12, 1'b1, BIT_NS);
    rxd = 1'b1;
    wait_cycles(2 * CPB);
    check("post reset frame data", int'(data), 8'h12);
    check("post reset frame valid", valid_cyc_q.size(), 1);
    if (valid_cyc_q.size() == 1)
      check_range("post reset latency", latency(valid_cyc_q[0]), LAT_NOM - 1, LAT_NOM + 1);

    // ---------------- strobe exclusivity over the whole run ----------------
    check("strobes never coincide", both_cyc_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_uart_rx
